// File: rtl/e_mdu_if.sv
// e_mdu_if: bundle of the MDU operand, command and result signals.
//   master : pipeline side (drives operands/op/start/flush, reads busy/HI/LO/out)
//   slave  : the MDU itself
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] MDU_a;
    logic [WIDTH-1:0] MDU_b;
    logic [3:0]       CU_MDU_op;
    logic             MDU_start;
    logic             MDU_flush;
    logic             E_MDU_busy;
    logic [WIDTH-1:0] E_MDU_hi;
    logic [WIDTH-1:0] E_MDU_lo;
    logic [WIDTH-1:0] E_MDU_out;

    modport master (
        output MDU_a, MDU_b, CU_MDU_op, MDU_start, MDU_flush,
        input  E_MDU_busy, E_MDU_hi, E_MDU_lo, E_MDU_out
    );

    modport slave (
        input  MDU_a, MDU_b, CU_MDU_op, MDU_start, MDU_flush,
        output E_MDU_busy, E_MDU_hi, E_MDU_lo, E_MDU_out
    );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the E stage, owner of HI/LO.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, aborts any running operation
//   bus    : e_mdu_if.slave
//            in  MDU_a, MDU_b     operands (latched at launch)
//            in  CU_MDU_op        0 none,1 mult,2 multu,3 div,4 divu,
//                                 5 mfhi,6 mflo,7 mthi,8 mtlo
//            in  MDU_start        launch strobe for ops 1-4
//            in  MDU_flush        cancels this cycle's launch/mthi/mtlo
//            out E_MDU_busy       operation in flight
//            out E_MDU_hi/lo      architectural HI/LO
//            out E_MDU_out        HI for mfhi, LO for mflo, else 0
//
// state  | meaning
// S_IDLE | accepts launch, mthi, mtlo
// S_BUSY | counting down; HI/LO written when counter reaches 1
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_md_op;
    logic             w_launch;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_ua;
    logic [WIDTH-1:0] w_ub;
    logic [WIDTH-1:0] w_ub_safe;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_out;

    assign w_is_md_op = (bus.CU_MDU_op >= OP_MULT) && (bus.CU_MDU_op <= OP_DIVU);
    assign w_launch   = bus.MDU_start && w_is_md_op && !bus.MDU_flush && (r_state == S_IDLE);

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed divide on magnitudes; most-negative / -1 wraps back to most-negative, rem 0.
    assign w_a_neg   = (r_op == OP_DIV) && r_a[WIDTH-1];
    assign w_b_neg   = (r_op == OP_DIV) && r_b[WIDTH-1];
    assign w_ua      = w_a_neg ? (~r_a + 1'b1) : r_a;
    assign w_ub      = w_b_neg ? (~r_b + 1'b1) : r_b;
    assign w_ub_safe = (w_ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_ub;
    assign w_q       = w_ua / w_ub_safe;
    assign w_r       = w_ua % w_ub_safe;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? (~w_q + 1'b1) : w_q;
    assign w_rem     = w_a_neg ? (~w_r + 1'b1) : w_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_op    <= bus.CU_MDU_op;
                        r_a     <= bus.MDU_a;
                        r_b     <= bus.MDU_b;
                        r_cnt   <= (bus.CU_MDU_op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        r_state <= S_BUSY;
                    end else if (!bus.MDU_flush) begin
                        if (bus.CU_MDU_op == OP_MTHI) r_hi <= bus.MDU_a;
                        if (bus.CU_MDU_op == OP_MTLO) r_lo <= bus.MDU_a;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        case (r_op)
                            OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                            OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero leaves HI/LO untouched.
                                if (r_b != '0) begin
                                    r_hi <= w_rem;
                                    r_lo <= w_quo;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_out = '0;
        case (bus.CU_MDU_op)
            OP_MFHI: w_out = r_hi;
            OP_MFLO: w_out = r_lo;
            default: w_out = '0;
        endcase
    end

    assign bus.E_MDU_busy = (r_state == S_BUSY);
    assign bus.E_MDU_hi   = r_hi;
    assign bus.E_MDU_lo   = r_lo;
    assign bus.E_MDU_out  = w_out;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu. dut0 uses default cycle counts (5/10),
// dut1 uses 1/1 to cover the single-cycle boundary.
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset0;
    logic reset1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    e_mdu_if #(.WIDTH(32)) bus0 ();
    e_mdu_if #(.WIDTH(32)) bus1 ();

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    e_mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic st, input logic fl);
        if (s == 0) begin
            bus0.CU_MDU_op = op; bus0.MDU_a = a; bus0.MDU_b = b;
            bus0.MDU_start = st; bus0.MDU_flush = fl;
        end else begin
            bus1.CU_MDU_op = op; bus1.MDU_a = a; bus1.MDU_b = b;
            bus1.MDU_start = st; bus1.MDU_flush = fl;
        end
    endtask

    function automatic logic busy_of(input int s);
        return (s == 0) ? bus0.E_MDU_busy : bus1.E_MDU_busy;
    endfunction

    function automatic logic [31:0] hi_of(input int s);
        return (s == 0) ? bus0.E_MDU_hi : bus1.E_MDU_hi;
    endfunction

    function automatic logic [31:0] lo_of(input int s);
        return (s == 0) ? bus0.E_MDU_lo : bus1.E_MDU_lo;
    endfunction

    // Launch one op, count busy cycles (bounded), then check HI/LO.
    task automatic run_op(input int s, input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        drive(s, op, a, b, 1'b1, 1'b0);
        step();
        drive(s, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (busy_of(s) && n < 100) begin
            n++;
            step();
        end
        chk({tag, " cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, " hi"}, hi_of(s), exp_hi);
        chk({tag, " lo"}, lo_of(s), exp_lo);
    endtask

    initial begin
        int n;
        reset0 = 1'b1;
        reset1 = 1'b1;
        drive(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) step();
        reset0 = 1'b0;
        reset1 = 1'b0;

        chk("rst busy", 32'(bus0.E_MDU_busy), 32'h0);
        chk("rst hi", bus0.E_MDU_hi, 32'h0);
        chk("rst lo", bus0.E_MDU_lo, 32'h0);
        chk("rst out", bus0.E_MDU_out, 32'h0);

        run_op(0, "mult", 4'd1, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(0, "multu", 4'd2, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(0, "div -7/2", 4'd3, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(0, "div min/-1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op(0, "divu 100/7", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // mthi / mtlo then divide by zero
        drive(0, 4'd7, 32'h1234, 32'h0, 1'b0, 1'b0);
        step();
        drive(0, 4'd8, 32'h5678, 32'h0, 1'b0, 1'b0);
        step();
        drive(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mthi", bus0.E_MDU_hi, 32'h1234);
        chk("mtlo", bus0.E_MDU_lo, 32'h5678);
        run_op(0, "divu by 0", 4'd4, 32'd7, 32'd0, 10, 32'h1234, 32'h5678);

        drive(0, 4'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mfhi out", bus0.E_MDU_out, 32'h1234);
        drive(0, 4'd6, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mflo out", bus0.E_MDU_out, 32'h5678);
        drive(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("none out", bus0.E_MDU_out, 32'h0);

        // flush cancels launch and mthi
        drive(0, 4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
        step();
        chk("flush busy", 32'(bus0.E_MDU_busy), 32'h0);
        drive(0, 4'd7, 32'hBEEF, 32'h0, 1'b0, 1'b1);
        step();
        drive(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush hi", bus0.E_MDU_hi, 32'h1234);
        chk("flush lo", bus0.E_MDU_lo, 32'h5678);

        // mtlo and restart attempts while busy are ignored
        drive(0, 4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        step();
        chk("busy c1", 32'(bus0.E_MDU_busy), 32'h1);
        drive(0, 4'd8, 32'hAAAA, 32'h0, 1'b0, 1'b0);
        step();
        drive(0, 4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        step();
        drive(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 2;
        while (bus0.E_MDU_busy && n < 100) begin
            n++;
            step();
        end
        chk("busy-ignore cycles", 32'(n), 32'd5);
        chk("busy-ignore hi", bus0.E_MDU_hi, 32'h0);
        chk("busy-ignore lo", bus0.E_MDU_lo, 32'd12);

        // back-to-back launch in the first idle cycle
        run_op(0, "b2b multu", 4'd2, 32'd5, 32'd6, 5, 32'h0, 32'd30);

        // reset during busy cycle 3
        drive(0, 4'd1, 32'd7, 32'd9, 1'b1, 1'b0);
        step();
        drive(0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset0 = 1'b1;
        step();
        reset0 = 1'b0;
        chk("rst-mid busy", 32'(bus0.E_MDU_busy), 32'h0);
        chk("rst-mid hi", bus0.E_MDU_hi, 32'h0);
        chk("rst-mid lo", bus0.E_MDU_lo, 32'h0);
        repeat (6) step();
        chk("rst-mid later lo", bus0.E_MDU_lo, 32'h0);

        // single-cycle configuration
        chk("n1 rst busy", 32'(bus1.E_MDU_busy), 32'h0);
        run_op(1, "n1 mult", 4'd1, 32'd3, 32'd5, 1, 32'h0, 32'd15);
        run_op(1, "n1 div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
